// File: rtl/mod_reconstruct_32_if.sv
// Handshake and operand bus for mod_reconstruct_32 (rebuilds A = Q*B + R).
// Optional rem_err signal present only when REC_REMCHECK_EN is defined.
interface mod_reconstruct_32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] R;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             rec_finish;
`ifdef REC_REMCHECK_EN
  logic             rem_err;

  modport master (
    output Q, B, R, start,
    input  busy, result, ovf, rec_finish, rem_err
  );

  modport slave (
    input  Q, B, R, start,
    output busy, result, ovf, rec_finish, rem_err
  );
`else
  modport master (
    output Q, B, R, start,
    input  busy, result, ovf, rec_finish
  );

  modport slave (
    input  Q, B, R, start,
    output busy, result, ovf, rec_finish
  );
`endif
endinterface

// File: rtl/mod_reconstruct_32.sv
// Sequential shift-add rebuild of A = Q*B + R, one quotient bit per clock.
// Optional REC_REMCHECK_EN adds rem_err = (R >= B), reported with rec_finish.
module mod_reconstruct_32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mod_reconstruct_32_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_qSh;
  logic [AW-1:0]    r_bSh;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_recFinish;
`ifdef REC_REMCHECK_EN
  logic             r_remErrPend;
  logic             r_remErr;
`endif

  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_accNext;

  // The accumulator is wide enough that Q*B+R never wraps before the final bit.
  assign w_addend  = r_qSh[0] ? r_bSh : '0;
  assign w_accNext = r_acc + w_addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_qSh       <= '0;
      r_bSh       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_recFinish <= 1'b0;
`ifdef REC_REMCHECK_EN
      r_remErrPend <= 1'b0;
      r_remErr     <= 1'b0;
`endif
    end else begin
      r_recFinish <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_qSh   <= bus.Q;
            r_bSh   <= {{(WIDTH+1){1'b0}}, bus.B};
            r_acc   <= {{(WIDTH+1){1'b0}}, bus.R};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= MUL;
`ifdef REC_REMCHECK_EN
            r_remErrPend <= (bus.R >= bus.B);
`endif
          end
        end
        MUL: begin
          r_acc <= w_accNext;
          r_qSh <= r_qSh >> 1;
          r_bSh <= r_bSh << 1;
          r_cnt <= r_cnt + CW'(1);
          // Outputs are loaded from the last partial sum so rec_finish coincides with DONE.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_result    <= w_accNext[WIDTH-1:0];
            r_ovf       <= |w_accNext[AW-1:WIDTH];
            r_recFinish <= 1'b1;
            r_state     <= DONE;
`ifdef REC_REMCHECK_EN
            r_remErr    <= r_remErrPend;
`endif
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.result     = r_result;
  assign bus.ovf        = r_ovf;
  assign bus.rec_finish = r_recFinish;
`ifdef REC_REMCHECK_EN
  assign bus.rem_err    = r_remErr;
`endif
endmodule

// File: tb/tb_mod_reconstruct_32.sv
// Directed self-checking bench for mod_reconstruct_32 (A = Q*B + R rebuild).
// Latency is counted in edges from the accepting edge to the edge that samples rec_finish high.
module tb_mod_reconstruct_32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;

  always #5 clk = ~clk;

  mod_reconstruct_32_if #(.WIDTH(32)) bus ();

  mod_reconstruct_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic startOp(input logic [31:0] q, input logic [31:0] b, input logic [31:0] r);
    @(negedge clk);
    bus.Q = q; bus.B = b; bus.R = r; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Negedge n after the accepting edge shows the value the edge N+n samples.
  task automatic applyStimulus(input string tag, input logic [31:0] q, input logic [31:0] b,
                               input logic [31:0] r, input logic [31:0] expResult,
                               input logic expOvf, input logic expRemErr);
    int lat;
    lat = -1;
    startOp(q, b, r);
    bus.Q = ~q; bus.B = ~b; bus.R = ~r;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
      if (bus.rec_finish) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
    checkOutput({tag, "_result"}, 64'(bus.result), 64'(expResult));
    checkOutput({tag, "_ovf"}, 64'(bus.ovf), 64'(expOvf));
`ifdef REC_REMCHECK_EN
    checkOutput({tag, "_rem_err"}, 64'(bus.rem_err), 64'(expRemErr));
`else
    if (expRemErr === 1'bx) $display("[TB] unexpected remErr expectation");
`endif
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 64'(bus.rec_finish), 64'd0);
    checkOutput({tag, "_idle"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_held"}, 64'(bus.result), 64'(expResult));
  endtask

  initial begin
    int pulses;
    logic [31:0] seenResult;
    bus.Q = '0; bus.B = '0; bus.R = '0; bus.start = 1'b0;

    #12;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_result", 64'(bus.result), 64'd0);
    checkOutput("reset_ovf", 64'(bus.ovf), 64'd0);
    checkOutput("reset_finish", 64'(bus.rec_finish), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("t1", 32'd126, 32'd10, 32'd5, 32'd1265, 1'b0, 1'b0);
    applyStimulus("t2", 32'd40, 32'd13, 32'd7, 32'd527, 1'b0, 1'b0);
    applyStimulus("t3a", 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus("t3b", 32'd0, 32'd0, 32'h1234, 32'h1234, 1'b0, 1'b1);
    applyStimulus("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);

    // A start pulsed mid-operation must be dropped, not queued.
    startOp(32'd40, 32'd13, 32'd7);
    pulses = 0;
    seenResult = '0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 10) begin
        bus.Q = 32'd1; bus.B = 32'd1; bus.R = 32'd1; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.rec_finish) begin
        pulses++;
        seenResult = bus.result;
      end
    end
    checkOutput("t4_pulses", 64'(pulses), 64'd1);
    checkOutput("t4_result", 64'(seenResult), 64'd527);

    // Reset in the middle of an operation aborts it with no finish pulse.
    startOp(32'd126, 32'd10, 32'd5);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", 64'(bus.busy), 64'd0);
    checkOutput("t5_result", 64'(bus.result), 64'd0);
    checkOutput("t5_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.rec_finish) pulses++;
    end
    checkOutput("t5_no_finish", 64'(pulses), 64'd0);
    applyStimulus("t5_after", 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // A start held high through finish is re-accepted once back in IDLE.
    @(negedge clk);
    bus.Q = 32'd126; bus.B = 32'd10; bus.R = 32'd5; bus.start = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.rec_finish) begin
        pulses = n;
        break;
      end
    end
    checkOutput("hold_latency", 64'(pulses), 64'd33);
    @(negedge clk);
    checkOutput("hold_idle_gap", 64'(bus.busy), 64'd0);
    @(negedge clk);
    checkOutput("hold_reaccept", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.rec_finish) begin
        pulses = n;
        break;
      end
    end
    checkOutput("hold_second_finish", 64'(pulses != 0), 64'd1);
    checkOutput("hold_result", 64'(bus.result), 64'd1265);

`ifdef REC_REMCHECK_EN
    applyStimulus("t6a", 32'd3, 32'd13, 32'd13, 32'd52, 1'b0, 1'b1);
    applyStimulus("t6b", 32'd3, 32'd13, 32'd12, 32'd51, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
